// File: rtl/smem_bank_conflict_serializer.sv
// Shared-memory bank conflict serializer: captures one multi-lane request
// and issues it as bank-conflict-free passes, one pass per cycle.
module smem_bank_conflict_serializer #(
    parameter int NUM_REQS         = 4,
    parameter int NUM_BANKS        = 4,
    parameter int WORD_SIZE        = 4,
    parameter int WORD_ADDR_WIDTH  = 30,
    parameter int CORE_TAG_WIDTH   = 1,
    parameter int BANK_ADDR_OFFSET = 0,
    localparam int WORD_WIDTH      = 8 * WORD_SIZE
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_REQS-1:0]                         core_req_valid,
    input  logic [NUM_REQS-1:0]                         core_req_rw,
    input  logic [NUM_REQS-1:0][WORD_ADDR_WIDTH-1:0]    core_req_addr,
    input  logic [NUM_REQS-1:0][WORD_SIZE-1:0]          core_req_byteen,
    input  logic [NUM_REQS-1:0][WORD_WIDTH-1:0]         core_req_data,
    input  logic [CORE_TAG_WIDTH-1:0]                   core_req_tag,
    output logic [NUM_REQS-1:0]                         core_req_ready,
    output logic [NUM_REQS-1:0]                         smem_req_valid,
    output logic [NUM_REQS-1:0]                         smem_req_rw,
    output logic [NUM_REQS-1:0][WORD_ADDR_WIDTH-1:0]    smem_req_addr,
    output logic [NUM_REQS-1:0][WORD_SIZE-1:0]          smem_req_byteen,
    output logic [NUM_REQS-1:0][WORD_WIDTH-1:0]         smem_req_data,
    output logic [CORE_TAG_WIDTH-1:0]                   smem_req_tag,
    output logic                                        smem_req_last,
    input  logic [NUM_REQS-1:0]                         smem_req_ready,
    output logic [31:0]                                 perf_bank_conflicts
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_REQS-1:0]                      pending_q, pending_d;
    logic [NUM_REQS-1:0]                      rw_q, rw_d;
    logic [NUM_REQS-1:0][WORD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_REQS-1:0][WORD_SIZE-1:0]       byteen_q, byteen_d;
    logic [NUM_REQS-1:0][WORD_WIDTH-1:0]      data_q, data_d;
    logic [CORE_TAG_WIDTH-1:0]                tag_q, tag_d;
    logic [31:0]                              perf_q, perf_d;

    logic [NUM_REQS-1:0]  sel;
    logic [NUM_BANKS-1:0] taken;
    logic [BANK_BITS-1:0] bank;
    logic                 busy;
    logic                 last;
    logic                 fire;
    logic                 accept;
    logic                 capture;
    logic                 unused_ready;

    // Only bit 0 of the shared-memory ready is meaningful
    assign unused_ready = ^smem_req_ready;

    // Pass selection: lowest-index pending lane per bank
    always_comb begin
        sel   = '0;
        taken = '0;
        bank  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            bank = (NUM_BANKS > 1) ? addr_q[i][BANK_ADDR_OFFSET +: BANK_BITS] : '0;
            if (pending_q[i] && !taken[bank]) begin
                sel[i]      = 1'b1;
                taken[bank] = 1'b1;
            end
        end
    end

    assign busy    = (pending_q != '0);
    assign last    = busy && ((pending_q & ~sel) == '0);
    assign fire    = busy && smem_req_ready[0];
    assign accept  = !reset && (!busy || (fire && last));
    assign capture = accept && (core_req_valid != '0);

    assign core_req_ready      = {NUM_REQS{accept}};
    assign smem_req_valid      = pending_q & sel;
    assign smem_req_last       = last;
    assign smem_req_rw         = rw_q;
    assign smem_req_addr       = addr_q;
    assign smem_req_byteen     = byteen_q;
    assign smem_req_data       = data_q;
    assign smem_req_tag        = tag_q;
    assign perf_bank_conflicts = perf_q;

    // Next state: retire issued lanes, capture a new request over the clear
    always_comb begin
        pending_d = pending_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        byteen_d  = byteen_q;
        data_d    = data_q;
        tag_d     = tag_q;
        perf_d    = perf_q;
        if (fire) begin
            pending_d = pending_q & ~sel;
        end
        if (fire && !last) begin
            perf_d = perf_q + 32'd1;
        end
        if (capture) begin
            pending_d = core_req_valid;
            rw_d      = core_req_rw;
            addr_d    = core_req_addr;
            byteen_d  = core_req_byteen;
            data_d    = core_req_data;
            tag_d     = core_req_tag;
        end
    end

    // Holding register, pending mask and conflict counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            rw_q      <= '0;
            addr_q    <= '0;
            byteen_q  <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            perf_q    <= '0;
        end else begin
            pending_q <= pending_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            byteen_q  <= byteen_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            perf_q    <= perf_d;
        end
    end

endmodule

// File: tb/tb_smem_bank_conflict_serializer.sv
// Bench for smem_bank_conflict_serializer: directed requests, expected
// passes queued at issue time and checked by an independent monitor.
module tb_smem_bank_conflict_serializer;

    typedef logic [3:0][29:0] addr4_t;

    typedef struct {
        logic [3:0] vld;
        logic       last;
        logic       tag;
        addr4_t     addr;
    } pass_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [3:0]            core_req_valid;
    logic [3:0]            core_req_rw;
    logic [3:0][29:0]      core_req_addr;
    logic [3:0][3:0]       core_req_byteen;
    logic [3:0][31:0]      core_req_data;
    logic [0:0]            core_req_tag;
    logic [3:0]            core_req_ready;
    logic [3:0]            smem_req_valid;
    logic [3:0]            smem_req_rw;
    logic [3:0][29:0]      smem_req_addr;
    logic [3:0][3:0]       smem_req_byteen;
    logic [3:0][31:0]      smem_req_data;
    logic [0:0]            smem_req_tag;
    logic                  smem_req_last;
    logic [3:0]            smem_req_ready;
    logic [31:0]           perf_bank_conflicts;

    pass_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    smem_bank_conflict_serializer dut (
        .clk                 (clk),
        .reset               (reset),
        .core_req_valid      (core_req_valid),
        .core_req_rw         (core_req_rw),
        .core_req_addr       (core_req_addr),
        .core_req_byteen     (core_req_byteen),
        .core_req_data       (core_req_data),
        .core_req_tag        (core_req_tag),
        .core_req_ready      (core_req_ready),
        .smem_req_valid      (smem_req_valid),
        .smem_req_rw         (smem_req_rw),
        .smem_req_addr       (smem_req_addr),
        .smem_req_byteen     (smem_req_byteen),
        .smem_req_data       (smem_req_data),
        .smem_req_tag        (smem_req_tag),
        .smem_req_last       (smem_req_last),
        .smem_req_ready      (smem_req_ready),
        .perf_bank_conflicts (perf_bank_conflicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int i, input logic [29:0] a);
        return {a, 2'(i)};
    endfunction

    task automatic expect_pass(input logic [3:0] v, input logic l, input logic t, input addr4_t a);
        pass_t p;
        p.vld  = v;
        p.last = l;
        p.tag  = t;
        p.addr = a;
        sb.push_back(p);
    endtask

    // Drive a request and hold it until the edge that accepts it
    task automatic issue(input logic [3:0] m, input addr4_t a, input logic t);
        bit ok = 0;
        @(posedge clk);
        #1;
        core_req_valid = m;
        core_req_addr  = a;
        core_req_tag   = t;
        for (int i = 0; i < 4; i++) begin
            core_req_rw[i]     = 1'(i);
            core_req_byteen[i] = 4'b0001 << i;
            core_req_data[i]   = data_of(i, a[i]);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_req_ready[0]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got not-ready expected ready");
        end
        @(posedge clk);
        #1;
        core_req_valid = 4'b0000;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_req_ready[0] && smem_req_valid == 4'b0000) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    // Monitor: every accepted pass must match the next queued expectation
    always @(negedge clk) begin
        if (!reset && smem_req_ready[0] && smem_req_valid != 4'b0000) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pass: got valid %b expected none", smem_req_valid);
            end else begin
                pass_t p;
                p = sb.pop_front();
                chk("pass_valid", 64'(smem_req_valid), 64'(p.vld));
                chk("pass_last", 64'(smem_req_last), 64'(p.last));
                chk("pass_tag", 64'(smem_req_tag), 64'(p.tag));
                for (int i = 0; i < 4; i++) begin
                    if (p.vld[i]) begin
                        chk("lane_addr", 64'(smem_req_addr[i]), 64'(p.addr[i]));
                        chk("lane_data", 64'(smem_req_data[i]), 64'(data_of(i, p.addr[i])));
                        chk("lane_rw", 64'(smem_req_rw[i]), 64'(i % 2));
                        chk("lane_byteen", 64'(smem_req_byteen[i]), 64'(4'b0001 << i));
                    end
                end
            end
        end
    end

    initial begin
        addr4_t a_nc, a_fc, a_pc, a_b2;
        a_nc = {30'd3, 30'd2, 30'd1, 30'd0};
        a_fc = {30'd12, 30'd8, 30'd4, 30'd0};
        a_pc = {30'd5, 30'd7, 30'd4, 30'd0};
        a_b2 = {30'd0, 30'd3, 30'd2, 30'd1};

        reset           = 1'b1;
        core_req_valid  = '0;
        core_req_rw     = '0;
        core_req_addr   = '0;
        core_req_byteen = '0;
        core_req_data   = '0;
        core_req_tag    = '0;
        smem_req_ready  = 4'b1111;

        @(negedge clk);
        chk("rst_valid", 64'(smem_req_valid), 64'h0);
        chk("rst_last", 64'(smem_req_last), 64'h0);
        chk("rst_perf", 64'(perf_bank_conflicts), 64'h0);
        chk("rst_ready", 64'(core_req_ready), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(core_req_ready), 64'hF);

        // No conflict: single pass, ready in the same cycle
        expect_pass(4'b1111, 1'b1, 1'b0, a_nc);
        issue(4'b1111, a_nc, 1'b0);
        @(negedge clk);
        chk("nc_valid", 64'(smem_req_valid), 64'hF);
        chk("nc_last", 64'(smem_req_last), 64'h1);
        chk("nc_ready", 64'(core_req_ready), 64'hF);
        wait_idle();
        chk("nc_perf", 64'(perf_bank_conflicts), 64'd0);

        // Full conflict: four passes, last only on the fourth
        expect_pass(4'b0001, 1'b0, 1'b1, a_fc);
        expect_pass(4'b0010, 1'b0, 1'b1, a_fc);
        expect_pass(4'b0100, 1'b0, 1'b1, a_fc);
        expect_pass(4'b1000, 1'b1, 1'b1, a_fc);
        issue(4'b1111, a_fc, 1'b1);
        @(negedge clk);
        chk("fc_busy_ready", 64'(core_req_ready), 64'h0);
        wait_idle();
        chk("fc_perf", 64'(perf_bank_conflicts), 64'd3);

        // Partial conflict with a masked lane
        expect_pass(4'b1001, 1'b0, 1'b0, a_pc);
        expect_pass(4'b0010, 1'b1, 1'b0, a_pc);
        issue(4'b1011, a_pc, 1'b0);
        wait_idle();
        chk("pc_perf", 64'(perf_bank_conflicts), 64'd4);

        // Backpressure for three cycles during pass 2
        expect_pass(4'b0001, 1'b0, 1'b1, a_fc);
        expect_pass(4'b0010, 1'b0, 1'b1, a_fc);
        expect_pass(4'b0100, 1'b0, 1'b1, a_fc);
        expect_pass(4'b1000, 1'b1, 1'b1, a_fc);
        issue(4'b1111, a_fc, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        smem_req_ready = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(smem_req_valid), 64'h2);
            chk("bp_last", 64'(smem_req_last), 64'h0);
            chk("bp_addr", 64'(smem_req_addr[1]), 64'd4);
        end
        @(posedge clk);
        #1;
        smem_req_ready = 4'b1111;
        wait_idle();
        chk("bp_perf", 64'(perf_bank_conflicts), 64'd7);

        // Back-to-back: second request accepted during the final pass
        expect_pass(4'b0001, 1'b0, 1'b0, a_fc);
        expect_pass(4'b0010, 1'b0, 1'b0, a_fc);
        expect_pass(4'b0100, 1'b0, 1'b0, a_fc);
        expect_pass(4'b1000, 1'b1, 1'b0, a_fc);
        expect_pass(4'b1111, 1'b1, 1'b1, a_b2);
        issue(4'b1111, a_fc, 1'b0);
        issue(4'b1111, a_b2, 1'b1);
        @(negedge clk);
        chk("b2b_no_bubble", 64'(smem_req_valid), 64'hF);
        wait_idle();
        chk("b2b_perf", 64'(perf_bank_conflicts), 64'd10);

        // Reset during pass 2: request dropped, counter cleared
        expect_pass(4'b0001, 1'b0, 1'b1, a_fc);
        issue(4'b1111, a_fc, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(smem_req_valid), 64'h0);
        chk("mid_rst_perf", 64'(perf_bank_conflicts), 64'h0);
        chk("mid_rst_ready", 64'(core_req_ready), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(smem_req_valid), 64'h0);
        end
        chk("post_rst_ready", 64'(core_req_ready), 64'hF);
        chk("post_rst_perf", 64'(perf_bank_conflicts), 64'h0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
